// File: rtl/mul_div_unit.sv
// Iterative 32-step multiply/divide unit feeding the architectural HI/LO registers.
// Optional divide datapath (DIV/DIVU, divz) is compiled only when MDU_DIV_EN is defined.
module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             divz
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t                 r_state, w_next;
   logic [CNT_W-1:0]       r_cnt;
   logic [WIDTH-1:0]       r_a;
   logic [2*WIDTH-1:0]     r_acc;
   logic                   r_neg_res;
   logic [WIDTH-1:0]       r_hi, r_lo;
   logic                   r_busy, r_done;

   logic                   w_accept;
   logic                   w_rs_neg, w_rt_neg;
   logic [WIDTH-1:0]       w_rs_abs, w_rt_abs;
   logic [WIDTH:0]         w_add;
   logic [2*WIDTH-1:0]     w_mul_step, w_step, w_prod;
   logic [WIDTH-1:0]       w_res_hi, w_res_lo;

`ifdef MDU_DIV_EN
   logic                   r_is_div, r_neg_rem, r_divz;
   logic [WIDTH-1:0]       r_b, r_rs_orig;
   logic [WIDTH:0]         w_rem_sh;
   logic [WIDTH-1:0]       w_diff;
   logic [2*WIDTH-1:0]     w_div_step;
   logic                   w_res_divz;

   assign w_accept = start && (r_state == S_IDLE);
   assign divz     = r_divz;
`else
   // Without the divide datapath, divide requests are simply never accepted.
   assign w_accept = start && (r_state == S_IDLE) && !op[1];
   assign divz     = 1'b0;
`endif

   assign hi   = r_hi;
   assign lo   = r_lo;
   assign busy = r_busy;
   assign done = r_done;

   // Signed ops run on magnitudes; op[0]=0 selects the signed variants.
   assign w_rs_neg = !op[0] && rs_data[WIDTH-1];
   assign w_rt_neg = !op[0] && rt_data[WIDTH-1];
   assign w_rs_abs = w_rs_neg ? -rs_data : rs_data;
   assign w_rt_abs = w_rt_neg ? -rt_data : rt_data;

   assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
   assign w_mul_step = r_acc[0] ? {w_add, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

`ifdef MDU_DIV_EN
   assign w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_diff   = w_rem_sh[WIDTH-1:0] - r_b;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_div_step = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      if (w_rem_sh >= {1'b0, r_b})
         w_div_step = {w_diff, r_acc[WIDTH-2:0], 1'b1};
   end

   assign w_step = r_is_div ? w_div_step : w_mul_step;
`else
   assign w_step = w_mul_step;
`endif

   always_comb begin
      w_prod   = r_neg_res ? -r_acc : r_acc;
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
      w_res_divz = 1'b0;
      if (r_is_div) begin
         if (r_b == '0) begin
            w_res_hi   = r_rs_orig;
            w_res_lo   = '1;
            w_res_divz = 1'b1;
         end else begin
            w_res_lo = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            w_res_hi = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
         end
      end
`endif
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_accept) w_next = S_RUN;
         S_RUN:   if (r_cnt == CNT_W'(WIDTH - 1)) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_a       <= '0;
         r_acc     <= '0;
         r_neg_res <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
`ifdef MDU_DIV_EN
         r_is_div  <= 1'b0;
         r_neg_rem <= 1'b0;
         r_divz    <= 1'b0;
         r_b       <= '0;
         r_rs_orig <= '0;
`endif
      end else begin
         r_state <= w_next;
         r_done  <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (hi_we) r_hi <= wdata;
               if (lo_we) r_lo <= wdata;
               if (w_accept) begin
                  r_cnt     <= '0;
                  r_busy    <= 1'b1;
                  r_a       <= w_rs_abs;
                  r_neg_res <= w_rs_neg ^ w_rt_neg;
`ifdef MDU_DIV_EN
                  r_is_div  <= op[1];
                  r_neg_rem <= w_rs_neg;
                  r_b       <= w_rt_abs;
                  r_rs_orig <= rs_data;
                  r_divz    <= 1'b0;
                  r_acc     <= op[1] ? {{WIDTH{1'b0}}, w_rs_abs} : {{WIDTH{1'b0}}, w_rt_abs};
`else
                  r_acc     <= {{WIDTH{1'b0}}, w_rt_abs};
`endif
               end
            end
            S_RUN: begin
               r_cnt <= r_cnt + CNT_W'(1);
               r_acc <= w_step;
            end
            S_FIN: begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_hi   <= w_res_hi;
               r_lo   <= w_res_lo;
`ifdef MDU_DIV_EN
               r_divz <= w_res_divz;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expectations come from a behavioural model
// pushed at issue time and popped when done pulses.
module tb_mul_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] rs_data = '0, rt_data = '0, wdata = '0;
   logic         hi_we = 1'b0, lo_we = 1'b0;
   logic [W-1:0] hi, lo;
   logic         busy, done, divz;

   mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .divz(divz)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        divz;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic signed [63:0] sa, sbv, q, r;
      logic [63:0] ua, ub, p;
      sa  = {{32{a[31]}}, a};
      sbv = {{32{b[31]}}, b};
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      e.divz = 1'b0;
      p = '0;
      case (o)
         2'b00: p = sa * sbv;
         2'b01: p = ua * ub;
         2'b10: begin
            if (b == 0) begin
               p = {a, 32'hFFFFFFFF};
               e.divz = 1'b1;
            end else begin
               q = sa / sbv;
               r = sa % sbv;
               p = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 0) begin
               p = {a, 32'hFFFFFFFF};
               e.divz = 1'b1;
            end else begin
               q = ua / ub;
               r = ua % ub;
               p = {r[31:0], q[31:0]};
            end
         end
      endcase
      e.hi = p[63:32];
      e.lo = p[31:0];
      return e;
   endfunction

   function automatic exp_t pop_exp();
      exp_t e;
      if (sb.size() == 0) return 'x;
      e = sb.pop_front();
      m_hi = e.hi;
      m_lo = e.lo;
      return e;
   endfunction

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o;
      rs_data = a;
      rt_data = b;
      start = 1'b1;
      sb.push_back(model(o, a, b));
   endtask

   // Waits (bounded) for done; start is dropped after the first edge and optionally re-pulsed.
   task automatic wait_done(input int pulse_at, output int lat, output int busy_cyc, output bit got);
      lat = 0;
      busy_cyc = 0;
      got = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         start = (c == pulse_at);
         if (busy) busy_cyc++;
         if (done) begin
            lat = c - 1;
            got = 1'b1;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({hi, lo} !== 64'h0) begin
         n_err++; $display("FAIL reset_hilo: got %h_%h want 0", hi, lo);
      end
      n_cmp++;
      if ({busy, done, divz} !== 3'b000) begin
         n_err++; $display("FAIL reset_flags: busy/done/divz got %b want 000", {busy, done, divz});
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mult();
      int lat, bc; bit got; exp_t e;
      issue(2'b00, 32'hFFFFFFFD, 32'd5);
      wait_done(-1, lat, bc, got);
      e = pop_exp();
      n_cmp++;
      if (got !== 1'b1 || lat != 33) begin
         n_err++; $display("FAIL mult_latency: got=%0b lat=%0d want 33", got, lat);
      end
      n_cmp++;
      if (bc != 33) begin
         n_err++; $display("FAIL mult_busy_cycles: got %0d want 33", bc);
      end
      n_cmp++;
      if ({hi, lo, divz} !== {e.hi, e.lo, e.divz}) begin
         n_err++; $display("FAIL mult_result: got %h_%h divz=%b want %h_%h divz=%b", hi, lo, divz, e.hi, e.lo, e.divz);
      end
   endtask

   task automatic test_multu_ignore();
      int lat, bc, extra; bit got; exp_t e;
      issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(10, lat, bc, got);
      e = pop_exp();
      n_cmp++;
      if (got !== 1'b1 || lat != 33 || bc != 33) begin
         n_err++; $display("FAIL multu_timing: got=%0b lat=%0d busy=%0d want 33/33", got, lat, bc);
      end
      n_cmp++;
      if ({hi, lo} !== {e.hi, e.lo}) begin
         n_err++; $display("FAIL multu_result: got %h_%h want %h_%h", hi, lo, e.hi, e.lo);
      end
      extra = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      n_cmp++;
      if (extra != 0) begin
         n_err++; $display("FAIL multu_ignored_start: got %0d busy/done cycles want 0", extra);
      end
   endtask

`ifdef MDU_DIV_EN
   task automatic test_div();
      typedef struct packed { logic [1:0] o; logic [31:0] a; logic [31:0] b; } stim_t;
      stim_t cases[6];
      int lat, bc; bit got; exp_t e;
      cases[0] = {2'b10, 32'hFFFFFFF9, 32'd2};
      cases[1] = {2'b11, 32'd100, 32'd7};
      cases[2] = {2'b10, 32'h80000000, 32'hFFFFFFFF};
      cases[3] = {2'b10, 32'd7, 32'hFFFFFFFE};
      cases[4] = {2'b10, 32'hFFFFFFF9, 32'd0};
      cases[5] = {2'b11, 32'h64, 32'd0};
      for (int i = 0; i < 6; i++) begin
         issue(cases[i].o, cases[i].a, cases[i].b);
         wait_done(-1, lat, bc, got);
         e = pop_exp();
         n_cmp++;
         if (got !== 1'b1 || lat != 33) begin
            n_err++; $display("FAIL div_latency[%0d]: got=%0b lat=%0d want 33", i, got, lat);
         end
         n_cmp++;
         if ({hi, lo, divz} !== {e.hi, e.lo, e.divz}) begin
            n_err++; $display("FAIL div_result[%0d]: got %h_%h divz=%b want %h_%h divz=%b", i, hi, lo, divz, e.hi, e.lo, e.divz);
         end
      end
      issue(2'b01, 32'd2, 32'd3);
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (divz !== 1'b0) begin
         n_err++; $display("FAIL divz_clear_on_start: got %b want 0", divz);
      end
      wait_done(-1, lat, bc, got);
      e = pop_exp();
      n_cmp++;
      if (got !== 1'b1 || {hi, lo, divz} !== {e.hi, e.lo, e.divz}) begin
         n_err++; $display("FAIL multu_after_divz: got=%0b %h_%h divz=%b want %h_%h divz=%b", got, hi, lo, divz, e.hi, e.lo, e.divz);
      end
   endtask
`else
   task automatic test_div_disabled();
      int act;
      for (int k = 0; k < 2; k++) begin
         op = (k == 0) ? 2'b10 : 2'b11;
         rs_data = 32'd100;
         rt_data = 32'd7;
         start = 1'b1;
         act = 0;
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy || done) act++;
         end
         n_cmp++;
         if (act != 0 || divz !== 1'b0) begin
            n_err++; $display("FAIL div_disabled_ignored[%0d]: active=%0d divz=%b want 0/0", k, act, divz);
         end
         n_cmp++;
         if ({hi, lo} !== {m_hi, m_lo}) begin
            n_err++; $display("FAIL div_disabled_hilo[%0d]: got %h_%h want %h_%h", k, hi, lo, m_hi, m_lo);
         end
      end
   endtask
`endif

   task automatic test_reset_abort();
      int act; exp_t e;
      issue(2'b01, 32'd7, 32'd9);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b0;
      #1;
      e = sb.pop_back();
      m_hi = '0;
      m_lo = '0;
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_err++; $display("FAIL abort_flags: busy/done got %b want 00", {busy, done});
      end
      n_cmp++;
      if ({hi, lo} !== 64'h0) begin
         n_err++; $display("FAIL abort_hilo: got %h_%h want 0 (discarded %h_%h)", hi, lo, e.hi, e.lo);
      end
      @(negedge clk);
      rst = 1'b1;
      act = 0;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         if (done || busy) act++;
      end
      n_cmp++;
      if (act != 0) begin
         n_err++; $display("FAIL abort_no_done: got %0d busy/done cycles want 0", act);
      end
   endtask

   task automatic test_mthilo();
      int lat, bc; bit got; exp_t e;
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      n_cmp++;
      if ({hi, lo} !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
         n_err++; $display("FAIL idle_write: got %h_%h want a5a5a5a5_a5a5a5a5", hi, lo);
      end
      issue(2'b01, 32'd2, 32'd3);
      hi_we = 1'b1; wdata = 32'hDEADBEEF;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      n_cmp++;
      if ({hi, lo} !== {32'hDEADBEEF, 32'hA5A5A5A5}) begin
         n_err++; $display("FAIL write_with_start: got %h_%h want deadbeef_a5a5a5a5", hi, lo);
      end
      repeat (4) @(negedge clk);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h12345678;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      n_cmp++;
      if ({hi, lo} !== {32'hDEADBEEF, 32'hA5A5A5A5}) begin
         n_err++; $display("FAIL busy_write_ignored: got %h_%h want deadbeef_a5a5a5a5", hi, lo);
      end
      wait_done(-1, lat, bc, got);
      e = pop_exp();
      n_cmp++;
      if (got !== 1'b1 || {hi, lo} !== {e.hi, e.lo}) begin
         n_err++; $display("FAIL mthilo_result: got=%0b %h_%h want %h_%h", got, hi, lo, e.hi, e.lo);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bc; bit got; exp_t e;
      issue(2'b01, 32'hFFFFFFFF, 32'd2);
      wait_done(-1, lat, bc, got);
      e = pop_exp();
      n_cmp++;
      if (got !== 1'b1 || {hi, lo} !== {e.hi, e.lo}) begin
         n_err++; $display("FAIL b2b_first: got=%0b %h_%h want %h_%h", got, hi, lo, e.hi, e.lo);
      end
      issue(2'b00, 32'hFFFFFFFD, 32'd5);
      wait_done(-1, lat, bc, got);
      e = pop_exp();
      n_cmp++;
      if (got !== 1'b1 || lat != 33 || bc != 33) begin
         n_err++; $display("FAIL b2b_accept: got=%0b lat=%0d busy=%0d want 33/33", got, lat, bc);
      end
      n_cmp++;
      if ({hi, lo} !== {e.hi, e.lo}) begin
         n_err++; $display("FAIL b2b_second: got %h_%h want %h_%h", hi, lo, e.hi, e.lo);
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu_ignore();
`ifdef MDU_DIV_EN
      test_div();
`else
      test_div_disabled();
`endif
      test_reset_abort();
      test_mthilo();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
